// File: rtl/com_bus_arbiter.sv
// -----------------------------------------------------------------------------
// com_bus_arbiter
//
// Round-robin arbiter for the shared common instruction bus. Up to four cache
// blocks request the bus. The arbiter issues a registered one-hot grant and
// keeps it until the owner drops its request. If MAX_HOLD is non-zero, a
// tenure that reaches MAX_HOLD cycles is revoked by force. Between tenures the
// arbiter always inserts TURN_CYCLES idle cycles, so two caches never drive
// Address_Com / Data_Bus_Com / Data_in_Bus in the same cycle.
//
// Parameters
//   NUM_REQ      number of requesters. Fixed at 4, so pointer and ID are 2 bits.
//   MAX_HOLD     maximum number of consecutive grant cycles. 0 disables timeout.
//   TURN_CYCLES  number of all-zero grant cycles between tenures (1..15).
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset; its release is synchronised
//   Com_Bus_Req  level-sensitive request, bit i belongs to cache i
//   Com_Bus_Gnt  one-hot or zero grant, bit i goes to cache i
//   Gnt_valid    OR of the grant bits
//   Gnt_id       index of the current owner; holds the last owner when idle
//   Bus_busy     high while a tenure or a turnaround is in progress
//   Timeout      one-cycle pulse in the first turnaround cycle after a forced
//                revocation
// -----------------------------------------------------------------------------
module com_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_HOLD    = 64,
  parameter int TURN_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] Com_Bus_Req,
  output logic [NUM_REQ-1:0] Com_Bus_Gnt,
  output logic               Gnt_valid,
  output logic [1:0]         Gnt_id,
  output logic               Bus_busy,
  output logic               Timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic        TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [15:0] HOLD_LIMIT = 16'(MAX_HOLD);
  localparam logic [3:0]  TURN_LOAD  = 4'(TURN_CYCLES - 1);
  localparam logic [15:0] HOLD_SAT   = 16'hFFFF;

  state_t               state_q;
  logic [1:0]           rr_ptr_q;
  logic [15:0]          hold_cnt_q;
  logic [3:0]           turn_cnt_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [1:0]           gnt_id_q;
  logic                 timeout_q;
  logic                 run_q;

  logic                 arb_found;
  logic [1:0]           arb_id;
  logic [NUM_REQ-1:0]   arb_onehot;
  logic                 owner_req;
  logic                 release_now;
  logic                 force_now;

  // ---------------------------------------------------------------------------
  // Reset release synchroniser. The flop is cleared asynchronously together
  // with the rest of the state. It then goes high on the first edge after
  // rst_n rises. The FSM only moves while run_q is high, so the first
  // arbitration falls on the second edge after release. That keeps the
  // reset-release edge away from any grant decision.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration: scan from rr_ptr upward, modulo 4. The first set request
  // wins. The 2-bit index wraps by itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    arb_found = 1'b0;
    arb_id    = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && Com_Bus_Req[rr_ptr_q + 2'(i)]) begin
        arb_found = 1'b1;
        arb_id    = rr_ptr_q + 2'(i);
      end
    end
  end

  assign arb_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_id;

  // Release wins over timeout at the same edge: force_now is only true while
  // the owner is still requesting.
  assign owner_req   = Com_Bus_Req[gnt_id_q];
  assign release_now = !owner_req;
  assign force_now   = TIMEOUT_EN && owner_req && (hold_cnt_q == HOLD_LIMIT);

  // ---------------------------------------------------------------------------
  // Main FSM. All outputs come from registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples values from before the edge.
  // NOTE: this FSM has no memory array. Every register is cleared by the
  // asynchronous reset, so the grant drops as soon as rst_n falls, without a
  // clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      hold_cnt_q <= 16'd0;
      turn_cnt_q <= 4'd0;
      gnt_q      <= '0;
      gnt_id_q   <= 2'd0;
      timeout_q  <= 1'b0;
    end else if (run_q) begin
      // Timeout is a single-cycle pulse. It is cleared on every edge unless a
      // forced revocation sets it again below.
      timeout_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            gnt_q      <= arb_onehot;
            gnt_id_q   <= arb_id;
            hold_cnt_q <= 16'd1;
            state_q    <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (release_now || force_now) begin
            // The pointer moves past the owner on either kind of release, so
            // a timed-out requester that keeps requesting comes back last.
            gnt_q      <= '0;
            rr_ptr_q   <= gnt_id_q + 2'd1;
            turn_cnt_q <= TURN_LOAD;
            timeout_q  <= force_now;
            state_q    <= ST_TURN;
          end else if (hold_cnt_q != HOLD_SAT) begin
            hold_cnt_q <= hold_cnt_q + 16'd1;
          end
        end

        ST_TURN: begin
          if (turn_cnt_q != 4'd0) begin
            turn_cnt_q <= turn_cnt_q - 4'd1;
          end else if (arb_found) begin
            // The last turnaround cycle grants directly, without passing
            // through IDLE, so the gap is exactly TURN_CYCLES cycles.
            gnt_q      <= arb_onehot;
            gnt_id_q   <= arb_id;
            hold_cnt_q <= 16'd1;
            state_q    <= ST_GRANT;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Com_Bus_Gnt = gnt_q;
  assign Gnt_valid   = |gnt_q;
  assign Gnt_id      = gnt_id_q;
  assign Bus_busy    = (state_q != ST_IDLE);
  assign Timeout     = timeout_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_com_bus_arbiter
//
// Directed bench for com_bus_arbiter. It uses two instances:
//   dut_a: MAX_HOLD = 4, TURN_CYCLES = 1. Covers reset, single request,
//          round-robin order, timeout, the release/timeout tie and reset in
//          the middle of a tenure.
//   dut_b: MAX_HOLD = 0, TURN_CYCLES = 3. Covers a long tenure without
//          timeout and the 3-cycle turnaround gap.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point.
// -----------------------------------------------------------------------------
module tb_com_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a, req_b;

  logic [3:0] gnt_a, gnt_b;
  logic       valid_a, valid_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, busy_b;
  logic       to_a, to_b;

  int checks = 0;
  int errors = 0;

  com_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .TURN_CYCLES(1)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .Com_Bus_Req (req_a),
    .Com_Bus_Gnt (gnt_a),
    .Gnt_valid   (valid_a),
    .Gnt_id      (id_a),
    .Bus_busy    (busy_a),
    .Timeout     (to_a)
  );

  com_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(0), .TURN_CYCLES(3)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .Com_Bus_Req (req_b),
    .Com_Bus_Gnt (gnt_b),
    .Gnt_valid   (valid_b),
    .Gnt_id      (id_b),
    .Bus_busy    (busy_b),
    .Timeout     (to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Observed and expected are packed as {gnt, valid, id, busy, timeout}.
  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed gnt/valid/id/busy/to=%b expected=%b", tag, obs, exp);
    end
  endtask

  // The expected Gnt_valid is the bench's own OR of the expected grant.
  task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic t);
    check(tag, {gnt_a, valid_a, id_a, busy_a, to_a}, {g, |g, id, b, t});
  endtask

  task automatic check_b(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic t);
    check(tag, {gnt_b, valid_b, id_b, busy_b, to_b}, {g, |g, id, b, t});
  endtask

  initial begin
    int owner;

    rst_n = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;

    // ---------------- reset and single request ----------------
    #2;
    check_a("reset_a", 4'b0000, 2'd0, 1'b0, 1'b0);
    check_b("reset_b", 4'b0000, 2'd0, 1'b0, 1'b0);

    tick();
    rst_n = 1'b1;
    req_a = 4'b0100;
    tick();
    check_a("sync_holdoff", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_a("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    check_a("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    req_a = 4'b0000;
    tick();
    check_a("single_release", 4'b0000, 2'd2, 1'b1, 1'b0);
    tick();
    check_a("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // ---------------- reset mid-tenure ----------------
    req_a = 4'b1000;
    tick();
    check_a("pre_reset_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_a("async_reset_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    req_a = 4'b1001;
    tick();
    check_a("reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_a("reset_sync2", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_a("post_reset_winner", 4'b0001, 2'd0, 1'b1, 1'b0);

    // ---------------- round-robin fairness ----------------
    req_a = 4'b1111;
    owner = 0;
    for (int k = 0; k < 4; k++) begin
      check_a($sformatf("rr_o%0d_c1", owner), onehot(owner), 2'(owner), 1'b1, 1'b0);
      tick();
      check_a($sformatf("rr_o%0d_c2", owner), onehot(owner), 2'(owner), 1'b1, 1'b0);
      tick();
      check_a($sformatf("rr_o%0d_c3", owner), onehot(owner), 2'(owner), 1'b1, 1'b0);
      req_a[owner] = 1'b0;
      tick();
      check_a($sformatf("rr_o%0d_gap", owner), 4'b0000, 2'(owner), 1'b1, 1'b0);
      req_a[owner] = 1'b1;
      tick();
      owner = (owner + 1) % 4;
    end
    check_a("rr_wrap_to_0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // ---------------- timeout (MAX_HOLD = 4) ----------------
    // Owner 0 is in its first grant cycle.
    req_a = 4'b0011;
    for (int c = 2; c <= 4; c++) begin
      tick();
      check_a($sformatf("to_o0_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    check_a("to_pulse_o0", 4'b0000, 2'd0, 1'b1, 1'b1);
    tick();
    check_a("to_o1_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check_a($sformatf("to_o1_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    check_a("to_pulse_o1", 4'b0000, 2'd1, 1'b1, 1'b1);
    tick();
    check_a("to_back_o0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // ---------------- release at the timeout edge ----------------
    for (int c = 2; c <= 4; c++) begin
      tick();
      check_a($sformatf("tie_o0_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req_a = 4'b0010;
    tick();
    check_a("tie_no_timeout", 4'b0000, 2'd0, 1'b1, 1'b0);
    req_a = 4'b0011;
    tick();
    check_a("tie_ptr_advanced", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_a = 4'b0000;
    tick();
    check_a("tie_o1_release", 4'b0000, 2'd1, 1'b1, 1'b0);
    tick();
    check_a("tie_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // ---------------- TURN_CYCLES = 3, MAX_HOLD = 0 ----------------
    req_b = 4'b0001;
    tick();
    check_b("long_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 200; c++) begin
      tick();
      check_b($sformatf("long_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req_b = 4'b0010;
    for (int z = 1; z <= 3; z++) begin
      tick();
      check_b($sformatf("turn3_gap%0d", z), 4'b0000, 2'd0, 1'b1, 1'b0);
    end
    tick();
    check_b("turn3_next_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_b = 4'b0000;
    for (int z = 1; z <= 3; z++) begin
      tick();
      check_b($sformatf("turn3_end_gap%0d", z), 4'b0000, 2'd1, 1'b1, 1'b0);
    end
    tick();
    check_b("turn3_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    check_a("a_still_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
